// File: rtl/hs_chk_pkg.sv
// Shared types for the handshake window checker: per-channel FSM states
// and the sticky error codes reported on err_code.
`timescale 1ns/1ps
package hs_chk_pkg;

    // Sticky first-error code, two bits per channel on the err_code bus
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        TIMEOUT = 2'd1,
        GUARD   = 2'd2,
        WINDOW  = 2'd3
    } err_code_e;

    // A channel is either idle, waiting for req, or waiting for the ack
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ch_state_e;

endpackage

// File: rtl/hs_chk_channel.sv
// One handshake channel: watches a single req/ack pair, times the wait,
// enforces guard and window rules, and keeps a sticky first-error code.
`timescale 1ns/1ps
module hs_chk_channel
    import hs_chk_pkg::*;
#(
    parameter int MAX_LAT     = 16,
    parameter int OVERLAP_ERR = 0,
    localparam int LAT_W      = $clog2(MAX_LAT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       req,
    input  logic       ack,
    input  logic       guard,
    input  logic       win_close,
    output logic       pass,
    output logic       fail,
    output logic [1:0] err_code,
    output logic       overlap,
    output logic       busy
);

    ch_state_e        state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    err_code_e        code_q, code_d;
    err_code_e        fail_code;
    logic             overlap_q, overlap_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    // Next-state logic: the first matching rule in WAIT decides the check.
    // Guard outranks ack, ack outranks the window end, and the window end
    // outranks the latency limit.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        code_d    = code_q;
        overlap_d = overlap_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        fail_code = NONE;
        if (clr) begin
            state_d   = IDLE;
            lat_d     = '0;
            code_d    = NONE;
            overlap_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(1);
                    end
                end
                WAIT: begin
                    if (!guard) begin
                        fail_d    = 1'b1;
                        fail_code = GUARD;
                        state_d   = IDLE;
                        lat_d     = '0;
                    end else if (ack) begin
                        pass_d  = 1'b1;
                        state_d = IDLE;
                        lat_d   = '0;
                    end else if (win_close) begin
                        fail_d    = 1'b1;
                        fail_code = WINDOW;
                        state_d   = IDLE;
                        lat_d     = '0;
                    end else if (lat_q == LAT_W'(MAX_LAT)) begin
                        fail_d    = 1'b1;
                        fail_code = TIMEOUT;
                        state_d   = IDLE;
                        lat_d     = '0;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                        if ((OVERLAP_ERR != 0) && req) begin
                            overlap_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    lat_d   = '0;
                end
            endcase
            if (fail_d && (code_q == NONE)) begin
                code_d = fail_code;
            end
        end
    end

    // State, latency counter, sticky flags and registered result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            code_q    <= NONE;
            overlap_q <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            code_q    <= code_d;
            overlap_q <= overlap_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

    assign pass     = pass_q;
    assign fail     = fail_q;
    assign err_code = code_q;
    assign overlap  = overlap_q;
    assign busy     = (state_q == WAIT);

endmodule

// File: rtl/hs_window_checker.sv
// Multi-channel req/ack handshake checker: one hs_chk_channel per channel
// plus saturating global counters of pass and fail pulses.
`timescale 1ns/1ps
module hs_window_checker
    import hs_chk_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int MAX_LAT     = 16,
    parameter int CNT_W       = 16,
    parameter int OVERLAP_ERR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [NUM_CH-1:0]   req,
    input  logic [NUM_CH-1:0]   ack,
    input  logic [NUM_CH-1:0]   guard,
    input  logic [NUM_CH-1:0]   win_close,
    output logic [NUM_CH-1:0]   pass,
    output logic [NUM_CH-1:0]   fail,
    output logic [2*NUM_CH-1:0] err_code,
    output logic [NUM_CH-1:0]   overlap,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic [NUM_CH-1:0]   busy
);

    localparam int PC_W = $clog2(NUM_CH + 1);

    logic [PC_W-1:0]  pass_add, fail_add;
    logic [CNT_W:0]   pass_sum, fail_sum;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hs_chk_channel #(
            .MAX_LAT     (MAX_LAT),
            .OVERLAP_ERR (OVERLAP_ERR)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .req       (req[i]),
            .ack       (ack[i]),
            .guard     (guard[i]),
            .win_close (win_close[i]),
            .pass      (pass[i]),
            .fail      (fail[i]),
            .err_code  (err_code[2*i +: 2]),
            .overlap   (overlap[i]),
            .busy      (busy[i])
        );
    end

    // Popcount this cycle's pulses and add them, clamping at all-ones
    // instead of wrapping; the extra sum bit flags the overflow.
    always_comb begin
        pass_add = '0;
        fail_add = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pass_add = pass_add + PC_W'(pass[i]);
            fail_add = fail_add + PC_W'(fail[i]);
        end
        pass_sum   = {1'b0, pass_cnt_q} + (CNT_W + 1)'(pass_add);
        fail_sum   = {1'b0, fail_cnt_q} + (CNT_W + 1)'(fail_add);
        pass_cnt_d = pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
        fail_cnt_d = fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
        if (clr) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end
    end

    // Global counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_hs_window_checker.sv
// Self-checking bench for hs_window_checker. Each scenario task drives a
// channel pattern and pushes the pulses it expects onto a scoreboard; a
// negedge monitor pops and compares whenever the DUT pulses.
`timescale 1ns/1ps
module tb_hs_window_checker;

    localparam int NUM_CH      = 4;
    localparam int MAX_LAT     = 16;
    localparam int CNT_W       = 6;
    localparam int OVERLAP_ERR = 1;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                clr;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   ack;
    logic [NUM_CH-1:0]   guard;
    logic [NUM_CH-1:0]   win_close;
    logic [NUM_CH-1:0]   pass;
    logic [NUM_CH-1:0]   fail;
    logic [2*NUM_CH-1:0] err_code;
    logic [NUM_CH-1:0]   overlap;
    logic [CNT_W-1:0]    pass_cnt;
    logic [CNT_W-1:0]    fail_cnt;
    logic [NUM_CH-1:0]   busy;

    typedef struct {
        int               edge_n;
        logic [NUM_CH-1:0] pass_v;
        logic [NUM_CH-1:0] fail_v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   ecnt      = 0;
    int   checks    = 0;
    int   failures  = 0;
    int   exp_pass  = 0;
    int   exp_fail  = 0;

    hs_window_checker #(
        .NUM_CH      (NUM_CH),
        .MAX_LAT     (MAX_LAT),
        .CNT_W       (CNT_W),
        .OVERLAP_ERR (OVERLAP_ERR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req       (req),
        .ack       (ack),
        .guard     (guard),
        .win_close (win_close),
        .pass      (pass),
        .fail      (fail),
        .err_code  (err_code),
        .overlap   (overlap),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global edge index used to time expected pulses
    always @(posedge clk) ecnt++;

    // Scoreboard monitor: every pulse must match the oldest expectation,
    // and an expectation whose edge has passed unseen is reported missing
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].edge_n < ecnt) begin
                checks++;
                failures++;
                $display("[TB] FAIL missing_pulse: got none by edge %0d, required pass=%b fail=%b at edge %0d",
                         ecnt, sb[0].pass_v, sb[0].fail_v, sb[0].edge_n);
                void'(sb.pop_front());
            end
            if ((pass | fail) != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_pulse: got pass=%b fail=%b at edge %0d, required no pulse",
                             pass, fail, ecnt);
                end else begin
                    mon_e = sb.pop_front();
                    if (pass !== mon_e.pass_v || fail !== mon_e.fail_v || ecnt != mon_e.edge_n) begin
                        failures++;
                        $display("[TB] FAIL pulse_match: got pass=%b fail=%b at edge %0d, required pass=%b fail=%b at edge %0d",
                                 pass, fail, ecnt, mon_e.pass_v, mon_e.fail_v, mon_e.edge_n);
                    end
                end
            end
        end
    end

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n, input logic [NUM_CH-1:0] p, input logic [NUM_CH-1:0] f);
        sb.push_back('{edge_n: n, pass_v: p, fail_v: f});
        exp_pass = sat(exp_pass + $countones(p));
        exp_fail = sat(exp_fail + $countones(f));
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({pass, fail, err_code, overlap, busy, pass_cnt, fail_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got pass=%b fail=%b err=%b ovl=%b busy=%b pc=%0d fc=%0d, required all zero",
                     pass, fail, err_code, overlap, busy, pass_cnt, fail_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_idle: got busy=%b, required 0000", busy);
        end
    endtask

    task automatic test_pass();
        req = 4'b0001;
        push_exp(ecnt + 4, 4'b0001, 4'b0000);
        step();
        checks++;
        if (busy !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL pass_busy: got busy=%b, required 0001", busy);
        end
        req = 4'b0000;
        step();
        step();
        ack = 4'b0001;
        step();
        ack = 4'b0000;
        step();
        checks++;
        if (pass_cnt !== CNT_W'(exp_pass) || err_code[1:0] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL pass_count: got pass_cnt=%0d err0=%0d, required pass_cnt=%0d err0=0",
                     pass_cnt, err_code[1:0], exp_pass);
        end
    endtask

    task automatic test_timeout();
        req = 4'b0010;
        push_exp(ecnt + MAX_LAT + 1, 4'b0000, 4'b0010);
        step();
        req = 4'b0000;
        repeat (MAX_LAT - 1) step();
        checks++;
        if (busy !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL timeout_still_busy: got busy=%b at lat %0d, required 0010", busy, MAX_LAT);
        end
        step();
        step();
        checks++;
        if (err_code[3:2] !== 2'd1 || fail_cnt !== CNT_W'(exp_fail)) begin
            failures++;
            $display("[TB] FAIL timeout_code: got err1=%0d fail_cnt=%0d, required err1=1 fail_cnt=%0d",
                     err_code[3:2], fail_cnt, exp_fail);
        end
    endtask

    task automatic test_guard();
        req = 4'b0100;
        push_exp(ecnt + 3, 4'b0000, 4'b0100);
        step();
        req = 4'b0000;
        step();
        guard = 4'b1011;
        ack   = 4'b0100;
        step();
        guard = 4'b1111;
        ack   = 4'b0000;
        step();
        checks++;
        if (err_code[5:4] !== 2'd2 || fail_cnt !== CNT_W'(exp_fail)) begin
            failures++;
            $display("[TB] FAIL guard_code: got err2=%0d fail_cnt=%0d, required err2=2 fail_cnt=%0d",
                     err_code[5:4], fail_cnt, exp_fail);
        end
    endtask

    task automatic test_window();
        req = 4'b1000;
        push_exp(ecnt + 5, 4'b1000, 4'b0000);
        step();
        req = 4'b0000;
        repeat (3) step();
        win_close = 4'b1000;
        ack       = 4'b1000;
        step();
        win_close = 4'b0000;
        ack       = 4'b0000;
        step();
        checks++;
        if (err_code[7:6] !== 2'd0 || pass_cnt !== CNT_W'(exp_pass)) begin
            failures++;
            $display("[TB] FAIL window_inclusive: got err3=%0d pass_cnt=%0d, required err3=0 pass_cnt=%0d",
                     err_code[7:6], pass_cnt, exp_pass);
        end
        req = 4'b1000;
        push_exp(ecnt + 5, 4'b0000, 4'b1000);
        step();
        req = 4'b0000;
        repeat (3) step();
        win_close = 4'b1000;
        step();
        win_close = 4'b0000;
        ack       = 4'b1000;
        step();
        ack = 4'b0000;
        checks++;
        if (busy !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL window_late_ack: got busy=%b, required 0000", busy);
        end
        step();
        checks++;
        if (err_code[7:6] !== 2'd3) begin
            failures++;
            $display("[TB] FAIL window_code: got err3=%0d, required 3", err_code[7:6]);
        end
    endtask

    task automatic test_all_fail();
        req = 4'b1111;
        push_exp(ecnt + 2, 4'b0000, 4'b1111);
        step();
        req   = 4'b0000;
        guard = 4'b0000;
        step();
        guard = 4'b1111;
        step();
        checks++;
        if (fail_cnt !== CNT_W'(exp_fail) || err_code !== 8'b11_10_01_10) begin
            failures++;
            $display("[TB] FAIL all_fail: got fail_cnt=%0d err=%b, required fail_cnt=%0d err=11100110",
                     fail_cnt, err_code, exp_fail);
        end
    endtask

    task automatic test_overlap();
        req = 4'b0001;
        push_exp(ecnt + 3, 4'b0001, 4'b0000);
        step();
        step();
        checks++;
        if (overlap !== 4'b0001 || busy !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL overlap_flag: got overlap=%b busy=%b, required overlap=0001 busy=0001", overlap, busy);
        end
        req = 4'b0000;
        ack = 4'b0001;
        step();
        ack = 4'b0000;
        step();
        req = 4'b0010;
        ack = 4'b0010;
        push_exp(ecnt + 2, 4'b0010, 4'b0000);
        step();
        checks++;
        if (busy !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL min_latency_ack_ignored: got busy=%b, required 0010", busy);
        end
        step();
        req = 4'b0000;
        ack = 4'b0000;
        checks++;
        if (busy !== 4'b0000 || overlap !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL deciding_req: got busy=%b overlap=%b, required busy=0000 overlap=0001", busy, overlap);
        end
        step();
        checks++;
        if (pass_cnt !== CNT_W'(exp_pass)) begin
            failures++;
            $display("[TB] FAIL overlap_pass_cnt: got %0d, required %0d", pass_cnt, exp_pass);
        end
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 16; r++) begin
            req = 4'b1111;
            push_exp(ecnt + 2, 4'b0000, 4'b1111);
            step();
            req   = 4'b0000;
            guard = 4'b0000;
            step();
            guard = 4'b1111;
            step();
            checks++;
            if (fail_cnt !== CNT_W'(exp_fail)) begin
                failures++;
                $display("[TB] FAIL saturation round %0d: got fail_cnt=%0d, required %0d", r, fail_cnt, exp_fail);
            end
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (busy !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL reset_mid_busy: got busy=%b, required 0100", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_pass = 0;
        exp_fail = 0;
        checks++;
        if ({pass, fail, err_code, overlap, busy, pass_cnt, fail_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_async: got err=%b ovl=%b busy=%b pc=%0d fc=%0d, required all zero",
                     err_code, overlap, busy, pass_cnt, fail_cnt);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 4'b0000 || fail_cnt !== 6'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_discard: got busy=%b fail_cnt=%0d, required busy=0000 fail_cnt=0", busy, fail_cnt);
        end
    endtask

    task automatic test_clr();
        req = 4'b0101;
        push_exp(ecnt + 2, 4'b0001, 4'b0100);
        step();
        req   = 4'b0000;
        ack   = 4'b0001;
        guard = 4'b1011;
        step();
        ack   = 4'b0000;
        guard = 4'b1111;
        step();
        checks++;
        if (pass_cnt !== CNT_W'(exp_pass) || fail_cnt !== CNT_W'(exp_fail) || err_code !== 8'b00_10_00_00) begin
            failures++;
            $display("[TB] FAIL clr_setup: got pc=%0d fc=%0d err=%b, required pc=%0d fc=%0d err=00100000",
                     pass_cnt, fail_cnt, err_code, exp_pass, exp_fail);
        end
        req = 4'b0010;
        step();
        req = 4'b0000;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
        checks++;
        if (busy !== 4'b0000 || pass_cnt !== 6'd0 || fail_cnt !== 6'd0 || err_code !== 8'd0 || overlap !== 4'd0) begin
            failures++;
            $display("[TB] FAIL clr_state: got busy=%b pc=%0d fc=%0d err=%b ovl=%b, required all zero",
                     busy, pass_cnt, fail_cnt, err_code, overlap);
        end
        ack = 4'b0010;
        step();
        ack = 4'b0000;
        repeat (MAX_LAT + 2) step();
        checks++;
        if (busy !== 4'b0000 || fail_cnt !== 6'd0 || pass_cnt !== 6'd0) begin
            failures++;
            $display("[TB] FAIL clr_aborted: got busy=%b pc=%0d fc=%0d, required busy=0000 pc=0 fc=0",
                     busy, pass_cnt, fail_cnt);
        end
    endtask

    // Watchdog: the sequence is a few hundred cycles long
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by 100000 ns, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        req       = '0;
        ack       = '0;
        guard     = '1;
        win_close = '0;
        test_reset();
        test_pass();
        test_timeout();
        test_guard();
        test_window();
        test_all_fail();
        test_overlap();
        test_saturation();
        test_reset_mid();
        test_clr();
        repeat (2) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs_window_checker.md
Name: hs_window_checker

Overview:
- Synthesizable, multi-channel RTL checker for req/ack handshakes.
- Each channel enforces three rules on every request:
  - the ack arrives 1..MAX_LAT cycles after req;
  - the guard stays high for the whole wait;
  - the ack arrives no later than the first window-close pulse.
- Reports per-channel pass/fail pulses, sticky error codes and saturating global pass/fail counters.
- Sits beside handshaking blocks in simulation and on FPGA, where SVA is unavailable.

Parameters:
NUM_CH, 4, number of independent handshake channels
MAX_LAT, 16, max cycles from req sample to ack sample (>=1)
CNT_W, 16, width of global pass/fail counters
OVERLAP_ERR, 0, 1 = req seen while a check is in flight raises OVERLAP flag; 0 = ignored silently

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: counters, sticky codes, all channels to IDLE
req  in  NUM_CH  per-channel request, sampled level
ack  in  NUM_CH  per-channel acknowledge
guard  in  NUM_CH  per-channel condition that must hold throughout the wait
win_close  in  NUM_CH  per-channel window-end pulse; ack must occur at or before it
pass  out  NUM_CH  one-cycle pulse: check completed OK
fail  out  NUM_CH  one-cycle pulse: check failed
err_code  out  2*NUM_CH  sticky first-error code per channel: 0 none, 1 TIMEOUT, 2 GUARD, 3 WINDOW
overlap  out  NUM_CH  sticky overlap flag (only when OVERLAP_ERR=1)
pass_cnt  out  CNT_W  saturating total of pass pulses
fail_cnt  out  CNT_W  saturating total of fail pulses
busy  out  NUM_CH  channel in WAIT

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0;
  - all channels IDLE;
  - latency counters 0.
- Per-channel FSM: IDLE, WAIT.
- IDLE:
  - req=1 at edge T0 -> WAIT, lat<=1.
  - ack/guard/win_close ignored in IDLE, including an ack coincident with req (minimum latency is 1).
- WAIT: at each edge, evaluate in strict priority order. The first matching rule decides and the channel returns to IDLE:
  1. guard=0 -> fail, GUARD. Guard is also required on the ack cycle.
  2. ack=1 -> pass. This covers ack coincident with win_close; the window end is inclusive.
  3. win_close=1 -> fail, WINDOW.
  4. lat==MAX_LAT -> fail, TIMEOUT.
  5. Otherwise lat<=lat+1 and stay in WAIT.
- Checks are non-overlapping. req while in WAIT does not restart the check.
  - With OVERLAP_ERR=1, a req in WAIT that is not on the deciding edge sets overlap[ch].
  - req on the deciding edge is not accepted; a new check needs req in IDLE.
- pass/fail are registered: asserted the cycle after the deciding edge, for exactly 1 cycle.
- err_code records the first failure only and is held until clr or reset.
- pass_cnt/fail_cnt:
  - add popcount of the same-cycle pass/fail vectors;
  - saturate at 2^CNT_W-1, never wrap.
- clr takes priority over all channel activity in that cycle:
  - in-flight checks are aborted with no pulse;
  - no counter increment that cycle.
- Reset mid-check: the check is discarded, no pulse.
- lat width is $clog2(MAX_LAT+1).

Decomposition:
- Package hs_chk_pkg:
  - err_code_e enum (NONE, TIMEOUT, GUARD, WINDOW);
  - ch_state_e enum (IDLE, WAIT).
- Sub-module hs_chk_channel: one-channel FSM + lat counter + sticky code. Instantiated NUM_CH times via generate.
- Top level holds the counters and popcount.

Test Plan:
- NUM_CH=4, MAX_LAT=16: req[0] at edge 1, ack[0] at edge 4, guard high -> pass[0] pulse after edge 4; pass_cnt=1; err_code[0]=0.
- req[1] at edge 1, no ack through edge 17 -> fail[1] after edge 17 (lat=16); err_code[1]=TIMEOUT.
- req[2], guard[2] drops at edge 3, ack at edge 3 -> fail[2]; err_code[2]=GUARD (guard beats ack).
- req[3], win_close[3] at edge 5:
  - ack at edge 5 -> pass;
  - repeat with ack at edge 6 -> fail at edge 5, WINDOW.
- All 4 channels fail on the same edge -> fail_cnt +4 in one cycle.
- Preload fail_cnt near 2^CNT_W-1 -> it saturates and does not wrap.
- OVERLAP_ERR=1: second req[0] while busy -> overlap[0]=1; the first check still completes normally.
- clr asserted mid-WAIT -> busy=0, no pulse, counters 0.
- rst_n low mid-WAIT -> all outputs 0 asynchronously.
